// File: rtl/dds_pkg.sv
// Shared definitions for the multi-waveform DDS: waveform codes and default widths.
package dds_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        WAVE_SAW  = 2'd0,
        WAVE_TRI  = 2'd1,
        WAVE_SQR  = 2'd2,
        WAVE_SINE = 2'd3
    } wave_t;

endpackage

// File: rtl/dds_sine_rom.sv
// Full-period sine lookup, offset-binary, one-cycle registered read.
// The table is computed at elaboration (integer Bhaskara form), so synthesis folds it into a ROM.
module dds_sine_rom #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] a,
    output logic [DATA_W-1:0] spo
);

    // sin(x) ~ 16t / (5H^2 - 4t) with t = p*(H-p) over each half period of H steps
    function automatic logic [DATA_W-1:0] sine_value(input logic [ADDR_W-1:0] idx);
        longint h;
        longint p;
        longint t;
        longint d;
        longint num;
        longint full;
        longint v;
        h    = longint'(1) << (ADDR_W - 1);
        p    = longint'(idx[ADDR_W-2:0]);
        t    = p * (h - p);
        d    = 5 * h * h - 4 * t;
        full = (longint'(1) << DATA_W) - 1;
        if (idx[ADDR_W-1]) begin
            num = d - 16 * t;
        end else begin
            num = d + 16 * t;
        end
        v = (full * num + d) / (2 * d);
        return v[DATA_W-1:0];
    endfunction

    // NOTE: ROM/RAM output registers carry no reset; that keeps them mappable onto block memory.
    always_ff @(posedge clk) begin
        spo <= sine_value(a);
    end

endmodule

// File: rtl/dds_multi_wave.sv
// Phase-accumulator DDS with four waveforms, phase offset and wrap-synchronised
// tuning-word / waveform updates so the output stays phase-continuous.
module dds_multi_wave
    import dds_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dds_en,
    input  logic [PHASE_W-1:0] ftw_in,
    input  logic               ftw_load,
    input  logic [1:0]         wave_sel,
    input  logic [ADDR_W-1:0]  phase_off,
    output logic [DATA_W-1:0]  q,
    output logic               q_valid,
    output logic               ftw_busy
);

    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] acc_sum;
    logic [PHASE_W-1:0] ftw_act;
    logic [PHASE_W-1:0] ftw_pend;
    logic               wrap;
    logic               commit;
    logic               pend;
    wave_t              wave_act;
    wave_t              wave_pend;

    logic [ADDR_W-1:0]  addr_next;
    logic [ADDR_W-1:0]  addr_r;
    wave_t              wave_r;
    logic               en_d1;

    logic               msb;
    logic [DATA_W-2:0]  tri_u;
    logic [DATA_W-1:0]  sine_q;
    logic [DATA_W-1:0]  wave_q;

    // Commit only at a wrap, while stopped, or when a zero tuning word means no wrap will come.
    always_comb begin
        {wrap, acc_sum} = {1'b0, acc} + {1'b0, ftw_act};
        commit          = pend && (wrap || !dds_en || (ftw_act == '0));
        addr_next       = acc[PHASE_W-1 -: ADDR_W] + phase_off;
    end

    // NOTE: every clocked process assigns with <= so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (dds_en) begin
            acc <= acc_sum;
        end else begin
            acc <= '0;
        end
    end

    // A load coinciding with a commit: the older value commits, the newer one stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_act   <= '0;
            wave_act  <= WAVE_SAW;
            ftw_pend  <= '0;
            wave_pend <= WAVE_SAW;
            pend      <= 1'b0;
        end else begin
            if (commit) begin
                ftw_act  <= ftw_pend;
                wave_act <= wave_pend;
            end
            if (ftw_load) begin
                ftw_pend  <= ftw_in;
                wave_pend <= wave_t'(wave_sel);
                pend      <= 1'b1;
            end else if (commit) begin
                pend <= 1'b0;
            end
        end
    end

    assign ftw_busy = pend;

    // E0: index and waveform select travel together into the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= '0;
            wave_r <= WAVE_SAW;
            en_d1  <= 1'b0;
        end else begin
            addr_r <= addr_next;
            wave_r <= wave_act;
            en_d1  <= dds_en;
        end
    end

    // Fed with the E0 index so its registered read lines up with addr_r.
    dds_sine_rom #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sine_rom (
        .clk (clk),
        .a   (addr_next),
        .spo (sine_q)
    );

    assign msb   = addr_r[ADDR_W-1];
    assign tri_u = addr_r[ADDR_W-2 -: DATA_W-1];

    // NOTE: the default assignment first means no path leaves wave_q unassigned, so no latch.
    always_comb begin
        wave_q = '0;
        case (wave_r)
            WAVE_SAW:  wave_q = addr_r[ADDR_W-1 -: DATA_W];
            WAVE_TRI:  wave_q = msb ? ~{tri_u, 1'b0} : {tri_u, 1'b0};
            WAVE_SQR:  wave_q = msb ? '0 : '1;
            WAVE_SINE: wave_q = sine_q;
            default:   wave_q = '0;
        endcase
    end

    // E1: registered, gated output.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q       <= en_d1 ? wave_q : '0;
            q_valid <= en_d1;
        end
    end

endmodule

// File: tb/tb_dds_multi_wave.sv
// Self-checking bench for dds_multi_wave: directed steps plus a randomized segment,
// all compared every cycle against a behavioural model of phase, load/commit and waveforms.
module tb_dds_multi_wave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dds_en = 1'b0;
    logic [31:0] ftw_in = '0;
    logic        ftw_load = 1'b0;
    logic [1:0]  wave_sel = '0;
    logic [7:0]  phase_off = '0;
    logic [7:0]  q;
    logic        q_valid;
    logic        ftw_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dds_multi_wave dut (
        .clk       (clk),
        .rst       (rst),
        .dds_en    (dds_en),
        .ftw_in    (ftw_in),
        .ftw_load  (ftw_load),
        .wave_sel  (wave_sel),
        .phase_off (phase_off),
        .q         (q),
        .q_valid   (q_valid),
        .ftw_busy  (ftw_busy)
    );

    // Behavioural model state
    typedef struct packed {
        bit       valid;
        bit [7:0] idx;
        bit [1:0] wave;
    } sample_t;

    sample_t   scheduled = '0;   // sample that emerges one clock later
    bit [31:0] m_phase = '0;
    bit [31:0] m_ftw = '0;
    bit [31:0] m_ftw_p = '0;
    bit [1:0]  m_wave = '0;
    bit [1:0]  m_wave_p = '0;
    bit        m_pend = 1'b0;
    int        exp_q = 0;
    int        exp_tol = 0;
    bit        exp_v = 1'b0;
    bit        exp_busy = 1'b0;

    function automatic int wave_ref(input bit [1:0] w, input int idx);
        case (w)
            2'd0:    return idx;
            2'd1:    return (idx < 128) ? 2 * idx : 255 - 2 * (idx - 128);
            2'd2:    return (idx < 128) ? 255 : 0;
            default: return int'($floor(127.5 + 127.5 * $sin(2.0 * 3.14159265358979 * idx / 256.0) + 0.5));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp, input int tol = 0);
        n_checks++;
        assert (((tol == 0) ? (obs === exp)
                            : ((obs + 64'(tol) >= exp) && (exp + 64'(tol) >= obs))) === 1'b1)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_edge();
        longint sum;
        bit     wrap;
        bit     commit;
        int     idx;
        if (rst) begin
            m_phase   = '0;
            m_ftw     = '0;
            m_ftw_p   = '0;
            m_wave    = '0;
            m_wave_p  = '0;
            m_pend    = 1'b0;
            scheduled = '0;
            exp_q     = 0;
            exp_tol   = 0;
            exp_v     = 1'b0;
            exp_busy  = 1'b0;
        end else begin
            exp_q   = scheduled.valid ? wave_ref(scheduled.wave, int'(scheduled.idx)) : 0;
            exp_tol = (scheduled.valid && scheduled.wave == 2'd3) ? 1 : 0;
            exp_v   = scheduled.valid;
            idx       = (int'(m_phase >> 24) + int'(phase_off)) % 256;
            scheduled = '{valid: dds_en, idx: idx[7:0], wave: m_wave};
            sum    = longint'(m_phase) + longint'(m_ftw);
            wrap   = (sum >= 64'h1_0000_0000);
            commit = m_pend && (wrap || !dds_en || (m_ftw == 0));
            m_phase = dds_en ? sum[31:0] : '0;
            if (commit) begin
                m_ftw  = m_ftw_p;
                m_wave = m_wave_p;
                m_pend = 1'b0;
            end
            if (ftw_load) begin
                m_ftw_p  = ftw_in;
                m_wave_p = wave_sel;
                m_pend   = 1'b1;
            end
            exp_busy = m_pend;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("q", q, exp_q, exp_tol);
        chk("q_valid", q_valid, exp_v);
        chk("ftw_busy", ftw_busy, exp_busy);
    endtask

    task automatic load(input logic [31:0] f, input logic [1:0] w);
        ftw_in   = f;
        wave_sel = w;
        ftw_load = 1'b1;
        tick();
        ftw_load = 1'b0;
    endtask

    task automatic wait_busy_low(input string tag, input int max_cycles);
        int n = 0;
        while (ftw_busy === 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, ftw_busy, 0);
    endtask

    task automatic wait_q(input string tag, input int value, input int max_cycles);
        int n = 0;
        while (q !== 8'(value) && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, q, value);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and first saw sweep
        rst = 1'b1;
        tick();
        tick();
        chk("rst_q", q, 0);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_busy", ftw_busy, 0);
        rst = 1'b0;
        tick();
        load(32'h0100_0000, 2'd0);
        chk("t1_busy_after_load", ftw_busy, 1);
        tick();
        chk("t1_commit_while_idle", ftw_busy, 0);
        dds_en = 1'b1;
        tick();
        chk("t1_not_valid_at_e0", q_valid, 0);
        for (int k = 0; k <= 256; k++) begin
            tick();
            chk("t1_saw_seq", q, k % 256);
        end

        // Tuning-word change waits for the wrap
        wait_q("t2_reach_100", 100, 300);
        load(32'h0200_0000, 2'd0);
        chk("t2_busy", ftw_busy, 1);
        wait_busy_low("t2_commit", 300);
        tick();
        chk("t2_last_old", q, 255);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_double_rate", q, 2 * k);
        end

        // Triangle then square, each switching in at index 0
        load(32'h0100_0000, 2'd1);
        wait_busy_low("t3_tri_commit", 300);
        tick();
        chk("t3_last_saw", q, 254);
        for (int k = 0; k < 256; k++) begin
            tick();
            chk("t3_tri", q, (k < 128) ? 2 * k : 255 - 2 * (k - 128));
        end
        load(32'h0100_0000, 2'd2);
        wait_busy_low("t3_sqr_commit", 300);
        tick();
        chk("t3_last_tri", q, 1);
        for (int k = 0; k < 256; k++) begin
            tick();
            chk("t3_sqr", q, (k < 128) ? 255 : 0);
        end

        // Sine with and without phase offset
        load(32'h0100_0000, 2'd3);
        wait_busy_low("t4_sine_commit", 300);
        for (int k = 0; k < 300; k++) tick();
        phase_off = 8'd64;
        for (int k = 0; k < 20; k++) tick();

        // Enable drop and restart
        dds_en = 1'b0;
        tick();
        chk("t5_valid_one_edge", q_valid, 1);
        tick();
        chk("t5_valid_dropped", q_valid, 0);
        chk("t5_q_zero", q, 0);
        tick();
        dds_en = 1'b1;
        tick();
        tick();
        chk("t5_restart_sine64", q, 255);
        dds_en = 1'b0;
        tick();
        load(32'h0300_0000, 2'd0);
        chk("t5_pend_disabled", ftw_busy, 1);
        tick();
        chk("t5_commit_disabled", ftw_busy, 0);
        phase_off = 8'd0;
        dds_en    = 1'b1;
        tick();
        tick();
        chk("t5_restart_saw0", q, 0);
        tick();
        chk("t5_restart_saw3", q, 3);

        // Zero tuning word, immediate commit, load on a wrap edge
        load(32'h0000_0000, 2'd0);
        wait_busy_low("t6_zero_commit", 300);
        for (int k = 0; k < 10; k++) tick();
        load(32'h0100_0000, 2'd0);
        chk("t6_busy_zero_ftw", ftw_busy, 1);
        tick();
        chk("t6_commit_zero_ftw", ftw_busy, 0);
        load(32'h0200_0000, 2'd2);
        begin
            int n = 0;
            while (!((longint'(m_phase) + longint'(m_ftw)) >= 64'h1_0000_0000) && n < 600) begin
                tick();
                n++;
            end
            chk("t6_wrap_found", ftw_busy, 1);
        end
        load(32'h0100_0000, 2'd1);
        chk("t6_load_on_wrap_pending", ftw_busy, 1);
        for (int k = 0; k < 100; k++) tick();
        chk("t6_still_pending", ftw_busy, 1);
        wait_busy_low("t6_second_commit", 300);

        // Randomized segment
        for (int k = 0; k < 1500; k++) begin
            int r;
            r = int'($urandom_range(99, 0));
            if (r < 3) dds_en = ~dds_en;
            if (r >= 3 && r < 6) phase_off = 8'($urandom);
            ftw_load = (r >= 6 && r < 10);
            if (ftw_load) begin
                ftw_in   = $urandom_range(32'h1000_0000, 32'h0100_0000);
                wave_sel = 2'($urandom);
            end
            tick();
            ftw_load = 1'b0;
        end

        // Reset mid-run drops a pending load
        dds_en = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        load(32'h0400_0000, 2'd1);
        chk("t6_pend_before_rst", ftw_busy, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_q", q, 0);
        chk("t6_rst_valid", q_valid, 0);
        chk("t6_rst_busy", ftw_busy, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("t6_pend_lost", ftw_busy, 0);
        for (int k = 0; k < 5; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
